// File: rtl/triple_counter_pkg.sv
// Shared constants for the modulo-3 phase counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package triple_counter_pkg;

  localparam int CNT_MOD = 3;
  localparam int CNT_W   = 2;

  localparam logic [CNT_W-1:0] PH0 = 2'd0;
  localparam logic [CNT_W-1:0] PH1 = 2'd1;
  localparam logic [CNT_W-1:0] PH2 = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Generic W-bit saturating incrementer, counts inc_i strobes and sticks at all-ones.
// Latency: 1 cycle from strobe edge to updated count.
// Backpressure: none; a strobe at saturation is silently absorbed.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: step by one on a strobe unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/triple_counter.sv
// Free-running mod-3 counter with registered terminal-count, one-hot phase and wrap diagnostics.
// Latency: 1 cycle from clock edge to all outputs; tc/phase always match count.
// Backpressure: none; advances on every edge while rst is low.
module triple_counter
  import triple_counter_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CNT_W-1:0]   count,
  output logic               tc,
  output logic [CNT_MOD-1:0] phase,
  output logic [WRAP_W-1:0]  wrap_cnt
);

  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               tc_q;
  logic               tc_d;
  logic [CNT_MOD-1:0] phase_q;
  logic [CNT_MOD-1:0] phase_d;
  logic               wrap_inc;

  // Next state plus its decode, so tc/phase are registered in step with count.
  // The unused code 3 falls into default and recovers to PH0 without counting a wrap.
  always_comb begin
    count_d = PH0;
    case (count_q)
      PH0:     count_d = PH1;
      PH1:     count_d = PH2;
      PH2:     count_d = PH0;
      default: count_d = PH0;
    endcase

    tc_d = (count_d == PH2);

    phase_d = 3'b000;
    case (count_d)
      PH0:     phase_d = 3'b001;
      PH1:     phase_d = 3'b010;
      PH2:     phase_d = 3'b100;
      default: phase_d = 3'b000;
    endcase

    wrap_inc = (count_q == PH2);
  end

  // State and decoded outputs, reset to phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= PH0;
      tc_q    <= 1'b0;
      phase_q <= 3'b001;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      phase_q <= phase_d;
    end
  end

  sat_counter #(
    .W (WRAP_W)
  ) u_wrap (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wrap_inc),
    .cnt_o (wrap_cnt)
  );

  assign count = count_q;
  assign tc    = tc_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_triple_counter.sv
// Scoreboard bench for triple_counter: default instance plus a WRAP_W=2 instance for saturation.
// Latency: expected values pushed when an edge is driven, popped and compared 1 ns after it.
// Backpressure: n/a.
module tb_triple_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [1:0] count;
  logic       tc;
  logic [2:0] phase;
  logic [7:0] wrap_cnt;

  logic [1:0] count2;
  logic       tc2;
  logic [2:0] phase2;
  logic [1:0] wrap2;

  always #5 clk = ~clk;

  triple_counter #(.WRAP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .tc       (tc),
    .phase    (phase),
    .wrap_cnt (wrap_cnt)
  );

  triple_counter #(.WRAP_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .count    (count2),
    .tc       (tc2),
    .phase    (phase2),
    .wrap_cnt (wrap2)
  );

  typedef struct {
    logic [1:0] cnt;
    logic       tc;
    logic [2:0] ph;
    logic [7:0] wrap;
    logic [1:0] cnt2;
    logic [1:0] wrap2;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, kept independently of the DUT.
  int m_cnt   = 0;
  int m_wrap  = 0;
  int m_cnt2  = 0;
  int m_wrap2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ph_of(input int c);
    case (c)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step(input bit r);
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_cnt2 = 0; m_wrap2 = 0;
    end else begin
      if (m_cnt == 2 && m_wrap < 255) m_wrap++;
      m_cnt = (m_cnt >= 2) ? 0 : m_cnt + 1;
      if (m_cnt2 == 2 && m_wrap2 < 3) m_wrap2++;
      m_cnt2 = (m_cnt2 >= 2) ? 0 : m_cnt2 + 1;
    end
  endtask

  // Drive one edge worth of stimulus, push the expectation, then compare.
  task automatic cycle(input bit r, input string tag);
    exp_t e;
    exp_t g;
    rst = r;
    model_step(r);
    e.cnt   = 2'(m_cnt);
    e.tc    = (m_cnt == 2);
    e.ph    = ph_of(m_cnt);
    e.wrap  = 8'(m_wrap);
    e.cnt2  = 2'(m_cnt2);
    e.wrap2 = 2'(m_wrap2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk({tag, ".count"}, 32'(count), 32'(g.cnt));
      chk({tag, ".tc"},    32'(tc),    32'(g.tc));
      chk({tag, ".phase"}, 32'(phase), 32'(g.ph));
      chk({tag, ".wrap"},  32'(wrap_cnt), 32'(g.wrap));
      chk({tag, ".count2"}, 32'(count2), 32'(g.cnt2));
      chk({tag, ".wrap2"},  32'(wrap2),  32'(g.wrap2));
    end
  endtask

  initial begin
    // Reset, then 12 free-running edges: 1,2,0,... ending with wrap 4.
    cycle(1'b1, "reset");
    for (int i = 0; i < 12; i++) cycle(1'b0, "run");
    chk("run_end.wrap", 32'(wrap_cnt), 32'd4);

    // Mid-run reset from count 1, then resume.
    cycle(1'b0, "pre_mid");
    chk("pre_mid.count_is_1", 32'(count), 32'd1);
    cycle(1'b1, "mid_reset");
    cycle(1'b0, "post_mid");

    // Held reset for 5 edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, "held_reset");

    // Run to a nonzero wrap count, then inject the illegal code 3.
    for (int i = 0; i < 4; i++) cycle(1'b0, "pre_illegal");
    force dut.count_q = 2'd3;
    #1;
    chk("forced.count", 32'(count), 32'd3);
    m_cnt = 3;
    @(negedge clk);
    release dut.count_q;
    cycle(1'b0, "illegal_recover");
    chk("illegal_recover.wrap_kept", 32'(wrap_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, "post_illegal");

    // Saturation on the narrow instance: 15 edges after reset, then keep running.
    cycle(1'b1, "sat_reset");
    for (int i = 0; i < 15; i++) cycle(1'b0, "sat_run");
    chk("sat.wrap2_at_15", 32'(wrap2), 32'd3);
    for (int i = 0; i < 6; i++) cycle(1'b0, "sat_hold");
    chk("sat.wrap2_held", 32'(wrap2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
